// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: lamp-side supervisor for the two-approach controller;
// latches the first rule violation with a cause code and drives a flashing-red override.
module traffic_light_monitor #(
    parameter int unsigned      CNT_W      = 33,
    parameter logic [CNT_W-1:0] MIN_YELLOW = CNT_W'(400),
    parameter logic [CNT_W-1:0] MAX_DWELL  = CNT_W'(0),
    parameter logic [CNT_W-1:0] FLASH_HALF = CNT_W'(50)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clr_fault,
    input  logic        R_a,
    input  logic        Y_a,
    input  logic        G_a,
    input  logic        R_b,
    input  logic        Y_b,
    input  logic        G_b,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic        flash_red,
    output logic        mon_active,
    output logic [15:0] cycle_cnt
);
    typedef enum logic [1:0] {ARM, MONITOR, FAULT} state_t;
    localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001;

    state_t           state, state_nxt;
    logic [2:0]       lamp_a, lamp_b, prev_a, prev_b, code_nxt;
    logic [CNT_W-1:0] ycnt_a, ycnt_b, dwell_cnt, dwell_nxt, flash_cnt;
    logic             onehot_a, onehot_b, legal, conflict, bad_seq, short_y, stuck, flash_wrap;

    function automatic logic is_onehot(input logic [2:0] l);
        return l == LR || l == LY || l == LG;
    endfunction

    function automatic logic seq_ok(input logic [2:0] p, input logic [2:0] c);
        return c == p || (p == LG && c == LY) || (p == LY && c == LR) || (p == LR && c == LG);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + CNT_W'(1);
    endfunction

    assign lamp_a     = {R_a, Y_a, G_a};
    assign lamp_b     = {R_b, Y_b, G_b};
    assign onehot_a   = is_onehot(lamp_a);
    assign onehot_b   = is_onehot(lamp_b);
    assign conflict   = !R_a && !R_b;
    assign legal      = onehot_a && onehot_b && !conflict;
    assign bad_seq    = !seq_ok(prev_a, lamp_a) || !seq_ok(prev_b, lamp_b);
    assign short_y    = (prev_a == LY && lamp_a == LR && ycnt_a < MIN_YELLOW) ||
                        (prev_b == LY && lamp_b == LR && ycnt_b < MIN_YELLOW);
    assign dwell_nxt  = (lamp_a != prev_a || lamp_b != prev_b) ? '0 : sat_inc(dwell_cnt);
    assign stuck      = MAX_DWELL != '0 && dwell_nxt >= MAX_DWELL;
    assign flash_wrap = flash_cnt == FLASH_HALF - CNT_W'(1);
    assign code_nxt   = conflict ? 3'd1 : !(onehot_a && onehot_b) ? 3'd2 : bad_seq ? 3'd3 :
                        short_y ? 3'd4 : stuck ? 3'd5 : 3'd0;
    assign fault      = state == FAULT;
    assign mon_active = state == MONITOR;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ARM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARM:     state_nxt = (enable && legal) ? MONITOR : ARM;
            MONITOR: state_nxt = !enable ? ARM : (code_nxt != 3'd0) ? FAULT : MONITOR;
            FAULT:   state_nxt = clr_fault ? ARM : FAULT;
            default: state_nxt = ARM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_a     <= '0;
            prev_b     <= '0;
            ycnt_a     <= '0;
            ycnt_b     <= '0;
            dwell_cnt  <= '0;
            flash_cnt  <= '0;
            flash_red  <= 1'b0;
            fault_code <= 3'd0;
            cycle_cnt  <= 16'd0;
        end else if (state == ARM) begin
            // Preload yellow counters so entering mid-yellow cannot flag a short yellow
            if (state_nxt == MONITOR) begin
                prev_a    <= lamp_a;
                prev_b    <= lamp_b;
                dwell_cnt <= '0;
                ycnt_a    <= Y_a ? MIN_YELLOW : '0;
                ycnt_b    <= Y_b ? MIN_YELLOW : '0;
            end
        end else if (state == MONITOR) begin
            if (state_nxt == FAULT) begin
                fault_code <= code_nxt;
                flash_red  <= 1'b1;
                flash_cnt  <= '0;
            end else if (state_nxt == ARM) begin
                ycnt_a    <= '0;
                ycnt_b    <= '0;
                dwell_cnt <= '0;
            end else begin
                prev_a    <= lamp_a;
                prev_b    <= lamp_b;
                ycnt_a    <= Y_a ? sat_inc(ycnt_a) : '0;
                ycnt_b    <= Y_b ? sat_inc(ycnt_b) : '0;
                dwell_cnt <= dwell_nxt;
                if (prev_a == LR && lamp_a == LG) cycle_cnt <= cycle_cnt + 16'd1;
            end
        end else if (clr_fault) begin
            fault_code <= 3'd0;
            flash_red  <= 1'b0;
            flash_cnt  <= '0;
            ycnt_a     <= '0;
            ycnt_b     <= '0;
            dwell_cnt  <= '0;
        end else begin
            flash_red <= flash_wrap ? ~flash_red : flash_red;
            flash_cnt <= flash_wrap ? '0 : flash_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: vector table plus directed sequences for sequencing,
// flash timing, yellow duration, watchdog and asynchronous reset.
module tb_traffic_light_monitor;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, N = 3'b000;

    typedef struct {
        logic       en;
        logic       clr;
        logic [2:0] a;
        logic [2:0] b;
        logic       f;
        logic [2:0] code;
        logic       mon;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, clr_fault = 1'b0;
    logic [2:0]  la = N, lb = N;
    logic        fault, flash_red, mon_active, w_fault, w_flash, w_mon;
    logic [2:0]  fault_code, w_code;
    logic [15:0] cycle_cnt, w_cnt;
    int          total = 0, bad = 0;
    vec_t        tv[34];

    traffic_light_monitor dut (
        .clk(clk), .reset(reset), .enable(enable), .clr_fault(clr_fault),
        .R_a(la[2]), .Y_a(la[1]), .G_a(la[0]), .R_b(lb[2]), .Y_b(lb[1]), .G_b(lb[0]),
        .fault(fault), .fault_code(fault_code), .flash_red(flash_red),
        .mon_active(mon_active), .cycle_cnt(cycle_cnt)
    );

    traffic_light_monitor #(.MAX_DWELL(33'd1000)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .clr_fault(clr_fault),
        .R_a(la[2]), .Y_a(la[1]), .G_a(la[0]), .R_b(lb[2]), .Y_b(lb[1]), .G_b(lb[0]),
        .fault(w_fault), .fault_code(w_code), .flash_red(w_flash),
        .mon_active(w_mon), .cycle_cnt(w_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic en, input logic clr, input logic [2:0] a,
                               input logic [2:0] b, input logic f, input logic [2:0] code,
                               input logic mon);
        vec_t r;
        r.en = en; r.clr = clr; r.a = a; r.b = b; r.f = f; r.code = code; r.mon = mon;
        return r;
    endfunction

    initial begin
        tv[0]  = v(0, 0, G, R, 0, 0, 0);
        tv[1]  = v(1, 0, G, G, 0, 0, 0);
        tv[2]  = v(1, 0, 3'b110, R, 0, 0, 0);
        tv[3]  = v(1, 0, G, R, 0, 0, 1);
        tv[4]  = v(1, 0, Y, R, 0, 0, 1);
        tv[5]  = v(1, 0, G, R, 1, 3, 0);
        tv[6]  = v(1, 0, G, G, 1, 3, 0);
        tv[7]  = v(1, 1, G, G, 0, 0, 0);
        tv[8]  = v(1, 0, G, R, 0, 0, 1);
        tv[9]  = v(1, 0, G, G, 1, 1, 0);
        tv[10] = v(1, 1, G, R, 0, 0, 0);
        tv[11] = v(1, 0, G, R, 0, 0, 1);
        tv[12] = v(1, 0, 3'b110, R, 1, 2, 0);
        tv[13] = v(1, 1, G, R, 0, 0, 0);
        tv[14] = v(1, 0, G, R, 0, 0, 1);
        tv[15] = v(1, 0, R, R, 1, 3, 0);
        tv[16] = v(1, 1, G, R, 0, 0, 0);
        tv[17] = v(1, 0, G, R, 0, 0, 1);
        tv[18] = v(1, 0, N, R, 1, 2, 0);
        tv[19] = v(1, 1, G, R, 0, 0, 0);
        tv[20] = v(1, 0, G, R, 0, 0, 1);
        tv[21] = v(0, 0, G, R, 0, 0, 0);
        tv[22] = v(0, 1, G, R, 0, 0, 0);
        tv[23] = v(1, 0, Y, R, 0, 0, 1);
        tv[24] = v(1, 0, R, R, 0, 0, 1);
        tv[25] = v(1, 0, R, G, 0, 0, 1);
        tv[26] = v(1, 0, Y, G, 1, 1, 0);
        tv[27] = v(1, 1, R, G, 0, 0, 0);
        tv[28] = v(1, 0, R, G, 0, 0, 1);
        tv[29] = v(1, 0, R, R, 1, 3, 0);
        tv[30] = v(1, 1, G, R, 0, 0, 0);
        tv[31] = v(1, 0, G, R, 0, 0, 1);
        tv[32] = v(1, 0, 3'b011, G, 1, 1, 0);
        tv[33] = v(1, 1, G, R, 0, 0, 0);

        step(2);
        chk("rst_fault", {31'd0, fault}, 0);
        chk("rst_code", {29'd0, fault_code}, 0);
        chk("rst_flash", {31'd0, flash_red}, 0);
        chk("rst_mon", {31'd0, mon_active}, 0);
        chk("rst_cnt", {16'd0, cycle_cnt}, 0);
        reset = 1'b1;
        step(1);

        foreach (tv[i]) begin
            enable = tv[i].en;
            clr_fault = tv[i].clr;
            la = tv[i].a;
            lb = tv[i].b;
            step(1);
            chk($sformatf("vec%0d_fault", i), {31'd0, fault}, {31'd0, tv[i].f});
            chk($sformatf("vec%0d_code", i), {29'd0, fault_code}, {29'd0, tv[i].code});
            chk($sformatf("vec%0d_mon", i), {31'd0, mon_active}, {31'd0, tv[i].mon});
        end
        clr_fault = 1'b0;
        chk("tab_cnt", {16'd0, cycle_cnt}, 0);

        // Three full legal phase cycles
        enable = 1'b1; la = G; lb = R;
        step(1);
        chk("seq_entry", {31'd0, mon_active}, 1);
        for (int i = 0; i < 3; i++) begin
            la = Y; step(500);
            la = R; step(1);
            lb = G; step(5);
            lb = Y; step(500);
            lb = R; step(1);
            la = G; step(1);
            chk($sformatf("seq%0d_cnt", i), {16'd0, cycle_cnt}, i + 1);
            chk($sformatf("seq%0d_fault", i), {31'd0, fault}, 0);
            chk($sformatf("seq%0d_wfault", i), {31'd0, w_fault}, 0);
        end
        enable = 1'b0;
        step(1);
        chk("dis_mon", {31'd0, mon_active}, 0);
        chk("dis_cnt_hold", {16'd0, cycle_cnt}, 3);

        // Conflict fault and flash timing
        enable = 1'b1; la = G; lb = R;
        step(1);
        la = G; lb = G;
        step(1);
        chk("cf_code", {29'd0, fault_code}, 1);
        chk("cf_flash0", {31'd0, flash_red}, 1);
        la = G; lb = R; enable = 1'b0;
        step(49);
        chk("fl_hi_end", {31'd0, flash_red}, 1);
        chk("fl_en_ignored", {31'd0, fault}, 1);
        step(1);
        chk("fl_lo", {31'd0, flash_red}, 0);
        step(49);
        chk("fl_lo_end", {31'd0, flash_red}, 0);
        step(1);
        chk("fl_hi2", {31'd0, flash_red}, 1);
        chk("fl_code_hold", {29'd0, fault_code}, 1);
        clr_fault = 1'b1;
        step(1);
        clr_fault = 1'b0;
        chk("clr_fault", {31'd0, fault}, 0);
        chk("clr_code", {29'd0, fault_code}, 0);
        chk("clr_flash", {31'd0, flash_red}, 0);
        chk("clr_mon", {31'd0, mon_active}, 0);

        // Yellow duration boundary
        enable = 1'b1; la = G; lb = R;
        step(1);
        la = Y; step(399);
        la = R; step(1);
        chk("y399_code", {29'd0, fault_code}, 4);
        clr_fault = 1'b1; step(1); clr_fault = 1'b0;
        la = G; step(1);
        la = Y; step(400);
        la = R; step(1);
        chk("y400_fault", {31'd0, fault}, 0);
        chk("y400_mon", {31'd0, mon_active}, 1);

        // Asynchronous reset mid-cycle clears cycle_cnt at once
        #3 reset = 1'b0;
        #1;
        chk("arst_cnt", {16'd0, cycle_cnt}, 0);
        chk("arst_mon", {31'd0, mon_active}, 0);
        reset = 1'b1;
        step(1);

        // Dwell watchdog
        enable = 1'b1; la = G; lb = R;
        step(1);
        step(999);
        chk("wd999_fault", {31'd0, w_fault}, 0);
        chk("wd999_mon", {31'd0, w_mon}, 1);
        step(1);
        chk("wd1000_code", {29'd0, w_code}, 5);
        chk("wd_off_fault", {31'd0, fault}, 0);
        step(10000);
        chk("wd_off_10k", {31'd0, fault}, 0);
        chk("wd_off_mon", {31'd0, mon_active}, 1);
        #3 reset = 1'b0;
        #1;
        chk("rstf_fault", {31'd0, w_fault}, 0);
        chk("rstf_code", {29'd0, w_code}, 0);
        chk("rstf_flash", {31'd0, w_flash}, 0);
        chk("rstf_mon", {31'd0, w_mon}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
